// File: rtl/nibble_ser_pkg.sv
// nibble_ser_pkg
//   Shared definitions for the nibble serializer: FSM state encoding and the
//   default parallel word width.
//   No ports (package).
package nibble_ser_pkg;

  localparam int NIBBLE_SER_DEFAULT_W = 4;

  // PARITY is only reachable when NIBBLE_SERIALIZER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/nibble_ser_bitcnt.sv
// nibble_ser_bitcnt
//   Bit position counter for one serial frame. Counts up from 0 and saturates
//   at DATA_W-1 so it never wraps inside a frame.
//   Ports:
//     clk         - clock, rising edge
//     reset       - synchronous, active-high; clears the count
//     i_clr       - clear the count to 0 (takes priority over i_en)
//     i_en        - advance the count by one (held once the last bit is reached)
//     o_last      - count is DATA_W-1: the last data bit is on the line
//     o_near_last - count is DATA_W-2: the next bit will be the last data bit
module nibble_ser_bitcnt
  import nibble_ser_pkg::*;
#(
  parameter int DATA_W = NIBBLE_SER_DEFAULT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last,
  output logic o_near_last
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] NEAR_IDX = CNT_W'(DATA_W - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last      = (r_cnt == LAST_IDX);
  assign o_near_last = (r_cnt == NEAR_IDX);

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer
//   Converts a DATA_W-bit parallel word into a serial bit stream, MSB-first or
//   LSB-first per word. Back-to-back words are sent without a gap when the next
//   word is offered in the final cycle of the current frame.
//   Optional feature: define NIBBLE_SERIALIZER_PARITY_EN to append one even
//   parity bit after the data bits (ser_last then marks the parity bit).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no frame in flight, ser_out at IDLE_LEVEL, ready for a word
//   SHIFT  | data bits on ser_out, one per cycle
//   PARITY | even parity of the captured word on ser_out (parity build)
//
//   Ports:
//     clk          - clock, rising edge
//     reset        - synchronous, active-high
//     in_data      - parallel word
//     in_valid     - in_data / in_msb_first are valid
//     in_msb_first - 1: send MSB first, 0: send LSB first
//     in_ready     - a word is accepted this cycle if in_valid is high
//     ser_out      - serial data bit (IDLE_LEVEL when ser_valid is low)
//     ser_valid    - ser_out carries a valid bit
//     ser_last     - final bit of the current frame
//     busy         - a frame is in flight
module nibble_serializer
  import nibble_ser_pkg::*;
#(
  parameter int   DATA_W     = NIBBLE_SER_DEFAULT_W,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_msb_first,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic              r_msb_first;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_ser_last;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  logic              r_parity;
`endif

  logic w_cnt_last;
  logic w_cnt_near_last;
  logic w_frame_end;
  logic w_accept;

  nibble_ser_bitcnt #(
    .DATA_W (DATA_W)
  ) u_bitcnt (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_accept),
    .i_en        (r_state == SHIFT),
    .o_last      (w_cnt_last),
    .o_near_last (w_cnt_near_last)
  );

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  assign w_frame_end = (r_state == PARITY);
`else
  assign w_frame_end = (r_state == SHIFT) && w_cnt_last;
`endif

  assign in_ready = !reset && ((r_state == IDLE) || w_frame_end);
  assign w_accept = in_valid && in_ready;

  // The shift register holds only the bits not yet sent; the bit being
  // driven now already sits in r_ser_out, so each shift loads the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_msb_first <= 1'b0;
      r_ser_out   <= IDLE_LEVEL;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= SHIFT;
      r_msb_first <= in_msb_first;
      r_ser_valid <= 1'b1;
      r_ser_last  <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      r_parity    <= ^in_data;
`endif
      if (in_msb_first) begin
        r_ser_out <= in_data[DATA_W-1];
        r_shreg   <= {in_data[DATA_W-2:0], 1'b0};
      end else begin
        r_ser_out <= in_data[0];
        r_shreg   <= {1'b0, in_data[DATA_W-1:1]};
      end
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_cnt_last) begin
            // Next bit is the last data bit; in the parity build the
            // parity cycle carries ser_last instead.
            r_ser_last <= w_cnt_near_last && !PARITY_EN;
            if (r_msb_first) begin
              r_ser_out <= r_shreg[DATA_W-1];
              r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
            end else begin
              r_ser_out <= r_shreg[0];
              r_shreg   <= {1'b0, r_shreg[DATA_W-1:1]};
            end
          end else begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            r_state     <= PARITY;
            r_ser_out   <= r_parity;
            r_ser_valid <= 1'b1;
            r_ser_last  <= 1'b1;
`else
            r_state     <= IDLE;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
`endif
          end
        end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        PARITY: begin
          r_state     <= IDLE;
          r_ser_out   <= IDLE_LEVEL;
          r_ser_valid <= 1'b0;
          r_ser_last  <= 1'b0;
        end
`endif
        default: begin
          r_state     <= IDLE;
          r_ser_out   <= IDLE_LEVEL;
          r_ser_valid <= 1'b0;
          r_ser_last  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
- REQ-001 Parameter DATA_W, default 4: width of the parallel word; legal values are 2 to 16.
- REQ-002 Parameter IDLE_LEVEL, default 1'b0: level driven on ser_out whenever ser_valid is low.
- REQ-003 Port clk, input, 1: clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1: reset, synchronous, active-high.
- REQ-005 Port in_data, input, DATA_W: parallel word from the upstream shift stage.
- REQ-006 Port in_valid, input, 1: in_data and in_msb_first are valid.
- REQ-007 Port in_msb_first, input, 1: 1 = MSB sent first, 0 = LSB sent first; sampled with in_data.
- REQ-008 Port in_ready, output, 1: block accepts a word in this cycle.
- REQ-009 Port ser_out, output, 1: serial data bit.
- REQ-010 Port ser_valid, output, 1: ser_out carries a valid bit.
- REQ-011 Port ser_last, output, 1: marks the final bit of the current frame.
- REQ-012 Port busy, output, 1: high while a frame is in flight.

Function
- REQ-013 The FSM shall use states IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
- REQ-014 Acceptance shall occur on a rising edge where in_valid and in_ready are both high: capture in_data into the shift register, latch in_msb_first, clear the bit counter, enter SHIFT.
- REQ-015 in_ready shall be high in IDLE, and in the final cycle of a frame (last data bit, or parity bit when enabled); it shall be low otherwise, and low while reset is high.
- REQ-016 The first bit shall appear on ser_out with ser_valid high in the cycle after acceptance; all serial outputs shall be registered.
- REQ-017 In SHIFT, ser_out shall present bit DATA_W-1 down to 0 (MSB-first) or 0 up to DATA_W-1 (LSB-first), one bit per cycle, for exactly DATA_W consecutive cycles.
- REQ-018 The bit counter shall be $clog2(DATA_W) bits wide and shall not wrap within a frame; the counter value DATA_W-1 denotes the last data bit.
- REQ-019 If a new word is accepted in the final frame cycle, its first bit shall follow in the next cycle with no gap in ser_valid.
- REQ-020 Otherwise the FSM shall return to IDLE, and ser_valid, ser_last and busy shall drop in the next cycle.
- REQ-021 When in_valid is high while in_ready is low, the word shall be ignored; upstream holds it until accepted.
- REQ-022 busy shall equal (state != IDLE).
- REQ-023 When ser_valid is low, ser_out shall equal IDLE_LEVEL.

Reset
- REQ-024 While reset is high at a clock edge, the block shall enter IDLE, set ser_valid=0, ser_last=0, busy=0 and ser_out=IDLE_LEVEL, clear the counter and the shift register, and drive in_ready=0.
- REQ-025 When reset is asserted mid-frame, the remaining bits shall be discarded, with no further ser_valid until a new acceptance.
- REQ-026 In the first cycle after reset deasserts, in_ready shall be 1.

Configuration
- REQ-027 Macro NIBBLE_SERIALIZER_PARITY_EN shall control the parity bit:
  - Defined: after the DATA_W data bits, one PARITY cycle drives ser_out = XOR of the captured word (even parity) with ser_valid=1; ser_last moves to the PARITY cycle; the frame is DATA_W+1 cycles.
  - Undefined: the PARITY state and logic are absent; ser_last is on data bit DATA_W-1; the frame is DATA_W cycles.

Structure
- REQ-028 The shared package nibble_ser_pkg shall hold the state enum (IDLE, SHIFT, PARITY) and the default-width constant (4).
- REQ-029 The bit counter shall be a sub-module, nibble_ser_bitcnt, with clear, enable and a last-bit flag; the FSM and shift register remain in the top level.

Verification
- REQ-030 in_data=4'b1011, msb_first=1 -> ser_out 1,0,1,1 on 4 consecutive valid cycles; ser_last on cycle 4; in_ready high on cycle 4.
- REQ-031 in_data=4'b1011, msb_first=0 -> ser_out 1,1,0,1; ser_last on cycle 4.
- REQ-032 in_valid held high with 4'hA then 4'h5, msb_first=1 -> 8 gapless valid cycles 1,0,1,0,0,1,0,1; ser_last on cycles 4 and 8.
- REQ-033 Reset for 1 cycle after the 2nd bit of 4'hF -> next cycle ser_valid=0 and ser_out=IDLE_LEVEL; in_ready=1 after reset release; no residual bits.
- REQ-034 in_valid with 4'h3 while busy sending 4'hC -> 4'h3 not captured until in_ready is high; the 4'hC frame is unaltered.
- REQ-035 With NIBBLE_SERIALIZER_PARITY_EN, 4'b0111 msb_first=1 -> ser_out 0,1,1,1 then parity 1 on cycle 5 with ser_last.
